// File: rtl/mill_modif_pkg.sv
// rtl/mill_modif_pkg.sv - shared types and symbol mapping for the modified Miller codec
package mill_modif_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    DATA,
    EOF0,
    EOF1
  } state_t;

  typedef enum logic [1:0] {
    SYM_X,
    SYM_Y,
    SYM_Z
  } sym_t;

  // A 1 is always X; a 0 is Z after a 0 and Y after a 1.
  function automatic sym_t encode_sym(input logic b, input logic prev);
    if (b) begin
      return SYM_X;
    end else if (prev) begin
      return SYM_Y;
    end else begin
      return SYM_Z;
    end
  endfunction

endpackage

// File: rtl/mill_modif_etu_cnt.sv
// rtl/mill_modif_etu_cnt.sv - bit-period cycle counter with clear and wrap
module mill_modif_etu_cnt #(
  parameter int ETU_CYCLES = 8,
  localparam int CW = $clog2(ETU_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_n,
  output logic          wrap
);

  assign wrap    = (count == CW'(ETU_CYCLES - 1));
  // count_n is exported so the top can register out_data for the upcoming cycle
  assign count_n = (clear || wrap) ? '0 : count + 1'b1;

  // counter register, wraps on symbol boundaries and holds 0 while cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_n;
    end
  end

endmodule

// File: rtl/mill_modif_mod.sv
// rtl/mill_modif_mod.sv - modified Miller encoder producing an active-low pause signal
module mill_modif_mod
  import mill_modif_pkg::*;
#(
  parameter int ETU_CYCLES   = 8,
  parameter int PAUSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_enable,
  input  logic in_valid,
  input  logic in_data,
  input  logic in_last,
  output logic in_ready,
  output logic out_data,
  output logic out_busy
);

  localparam int CW   = $clog2(ETU_CYCLES);
  localparam int HALF = ETU_CYCLES / 2;

  state_t          state, state_n;
  logic            bit_q, bit_n;
  logic            last_q, last_n;
  logic            prev_q, prev_n;
  logic            clear;
  logic            wrap;
  logic [CW-1:0]   k;
  logic [CW-1:0]   k_n;
  sym_t            sym_n;
  logic            pause_n;

  function automatic logic is_pause(input sym_t s, input logic [CW-1:0] kk);
    case (s)
      SYM_X:   return (int'(kk) >= HALF) && (int'(kk) < HALF + PAUSE_CYCLES);
      SYM_Z:   return int'(kk) < PAUSE_CYCLES;
      default: return 1'b0;
    endcase
  endfunction

  mill_modif_etu_cnt #(
    .ETU_CYCLES(ETU_CYCLES)
  ) u_etu_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .count  (k),
    .count_n(k_n),
    .wrap   (wrap)
  );

  // strobe only at the last cycle of SOF, or of a DATA symbol that is not the last bit
  assign in_ready = wrap && ((state == SOF) || ((state == DATA) && !last_q));

  // counter stays at 0 in IDLE and restarts whenever the frame ends or aborts
  assign clear = (state == IDLE) || (state_n == IDLE);

  // next state and next bit/last/prev; prev tracks the bit before the current symbol
  always_comb begin
    state_n = state;
    bit_n   = bit_q;
    last_n  = last_q;
    prev_n  = prev_q;
    if (!in_enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_n = SOF;
            bit_n   = 1'b0;
            last_n  = 1'b0;
            prev_n  = 1'b0;
          end
        end
        SOF, DATA: begin
          if (wrap) begin
            prev_n = bit_q;
            if (in_ready && in_valid) begin
              state_n = DATA;
              bit_n   = in_data;
              last_n  = in_last;
            end else begin
              state_n = EOF0;
              bit_n   = 1'b0;
            end
          end
        end
        EOF0: begin
          if (wrap) begin
            state_n = EOF1;
          end
        end
        EOF1: begin
          if (wrap) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // symbol of the upcoming cycle; EOF0 carries a 0 so it shares the DATA mapping
  always_comb begin
    sym_n = SYM_Y;
    case (state_n)
      SOF:        sym_n = SYM_Z;
      DATA, EOF0: sym_n = encode_sym(bit_n, prev_n);
      default:    sym_n = SYM_Y;
    endcase
    pause_n = is_pause(sym_n, k_n);
  end

  // state and registered outputs, all computed for the cycle that follows the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_q    <= 1'b0;
      last_q   <= 1'b0;
      prev_q   <= 1'b0;
      out_data <= 1'b1;
      out_busy <= 1'b0;
    end else begin
      state    <= state_n;
      bit_q    <= bit_n;
      last_q   <= last_n;
      prev_q   <= prev_n;
      out_data <= !pause_n;
      out_busy <= (state_n != IDLE);
    end
  end

endmodule
